accum_alu_n: RTL and testbench



---
 rtl/accum_alu_n.sv | 206 ++++++++++++++++++++
 tb/tb_accum_alu_n.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/accum_alu_n.sv
// Parametrised accumulator ALU: 16 operations against operand b, with
// single-cycle arithmetic/logic and one-bit-per-cycle shifts/rotates under start/busy/done.
module accum_alu_n #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             load,
  input  logic [3:0]       m,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] acc,
  output logic             of,
  output logic             zf,
  output logic             nf,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             is_sub_s;
  logic [WIDTH-1:0] opb_s;
  logic             c_s;
  logic [WIDTH:0]   arith_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_of_s;
  logic             alu_ovf_s;
  logic             alu_wr_s;
  logic [WIDTH:0]   step_s;

  // One shift/rotate step: returns {bit shifted out, new value}; op is m[2:0] of ops 8..15.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] a, input logic [2:0] op);
    logic [WIDTH:0] r;
    case (op)
      3'd0:    r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      3'd1:    r = {a[WIDTH-1], a[WIDTH-2:0], 1'b1};
      3'd2:    r = {a[0], 1'b0, a[WIDTH-1:1]};
      3'd3:    r = {a[0], 1'b1, a[WIDTH-1:1]};
      3'd4:    r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      3'd5:    r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      3'd6:    r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      3'd7:    r = {a[0], a[0], a[WIDTH-1:1]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Single-cycle operand selection and arithmetic/logic result.
  always_comb begin
    is_sub_s  = 1'b0;
    opb_s     = b;
    c_s       = cin;
    alu_wr_s  = 1'b1;
    case (m[2:0])
      3'd0:    begin is_sub_s = 1'b0; opb_s = b; c_s = cin; end
      3'd1:    begin is_sub_s = 1'b1; opb_s = b; c_s = cin; end
      3'd2:    begin is_sub_s = 1'b1; opb_s = b; c_s = cin; alu_wr_s = 1'b0; end
      3'd6:    begin is_sub_s = 1'b0; opb_s = WIDTH'(1); c_s = 1'b0; end
      3'd7:    begin is_sub_s = 1'b1; opb_s = WIDTH'(1); c_s = 1'b0; end
      default: begin is_sub_s = 1'b0; opb_s = b; c_s = cin; end
    endcase
    if (is_sub_s) begin
      arith_s = {1'b0, acc_q} - {1'b0, opb_s} - {{WIDTH{1'b0}}, c_s};
    end else begin
      arith_s = {1'b0, acc_q} + {1'b0, opb_s} + {{WIDTH{1'b0}}, c_s};
    end
    case (m[2:0])
      3'd3:    begin alu_res_s = acc_q & b; alu_of_s = 1'b0; alu_ovf_s = 1'b0; end
      3'd4:    begin alu_res_s = acc_q | b; alu_of_s = 1'b0; alu_ovf_s = 1'b0; end
      3'd5:    begin alu_res_s = ~acc_q;    alu_of_s = 1'b0; alu_ovf_s = 1'b0; end
      default: begin
        alu_res_s = arith_s[WIDTH-1:0];
        alu_of_s  = arith_s[WIDTH];
        if (is_sub_s) begin
          alu_ovf_s = (acc_q[WIDTH-1] != opb_s[WIDTH-1]) && (arith_s[WIDTH-1] != acc_q[WIDTH-1]);
        end else begin
          alu_ovf_s = (acc_q[WIDTH-1] == opb_s[WIDTH-1]) && (arith_s[WIDTH-1] != acc_q[WIDTH-1]);
        end
      end
    endcase
  end

  // Next-state logic for the IDLE/SHIFT sequencer, accumulator and flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    of_d    = of_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    step_s  = shift_step(acc_q, op_q);
    case (state_q)
      IDLE: begin
        if (load) begin
          acc_d  = b;
          of_d   = 1'b0;
          ovf_d  = 1'b0;
          zf_d   = (b == {WIDTH{1'b0}});
          nf_d   = b[WIDTH-1];
          done_d = 1'b1;
        end else if (start) begin
          if (m[3] == 1'b0) begin
            if (alu_wr_s) begin
              acc_d = alu_res_s;
            end else begin
              acc_d = acc_q;
            end
            of_d   = alu_of_s;
            ovf_d  = alu_ovf_s;
            zf_d   = (alu_res_s == {WIDTH{1'b0}});
            nf_d   = alu_res_s[WIDTH-1];
            done_d = 1'b1;
          end else if (amt == {SHW{1'b0}}) begin
            of_d   = 1'b0;
            ovf_d  = 1'b0;
            zf_d   = (acc_q == {WIDTH{1'b0}});
            nf_d   = acc_q[WIDTH-1];
            done_d = 1'b1;
          end else begin
            // ovf is cleared here so the sla sticky bit starts fresh.
            state_d = SHIFT;
            cnt_d   = amt;
            op_d    = m[2:0];
            of_d    = 1'b0;
            ovf_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = step_s[WIDTH-1:0];
        of_d  = step_s[WIDTH];
        zf_d  = (step_s[WIDTH-1:0] == {WIDTH{1'b0}});
        nf_d  = step_s[WIDTH-1];
        if (op_q == 3'd4) begin
          ovf_d = ovf_q | (acc_q[WIDTH-1] ^ acc_q[WIDTH-2]);
        end else begin
          ovf_d = 1'b0;
        end
        if (cnt_q == SHW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= {SHW{1'b0}};
      op_q    <= 3'd0;
      acc_q   <= {WIDTH{1'b0}};
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign acc  = acc_q;
  assign of   = of_q;
  assign zf   = zf_q;
  assign nf   = nf_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_accum_alu_n.sv
// Directed bench for accum_alu_n at WIDTH=8 with hand-computed expectations.
module tb_accum_alu_n;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       load;
  logic [3:0] m;
  logic [7:0] b;
  logic       cin;
  logic [2:0] amt;
  logic [7:0] acc;
  logic       of, zf, nf, ovf, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  accum_alu_n #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .load(load), .m(m), .b(b),
    .cin(cin), .amt(amt), .acc(acc), .of(of), .zf(zf), .nf(nf), .ovf(ovf),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; b = v;
    tick();
    load = 1'b0;
    chk("load_acc", 32'(acc), 32'(v));
    chk("load_done", 32'(done), 32'd1);
  endtask

  task automatic do_start(input logic [3:0] op, input logic [7:0] bv, input logic c, input logic [2:0] k);
    start = 1'b1; m = op; b = bv; cin = c; amt = k;
    tick();
    start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; load = 1'b0; m = 4'd0; b = 8'h00; cin = 1'b0; amt = 3'd0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_flags", 32'({of, zf, nf, ovf}), 32'h0);
    chk("rst_busy_done", 32'({busy, done}), 32'h0);

    // add with signed overflow
    do_load(8'h7F);
    do_start(4'd0, 8'h01, 1'b0, 3'd0);
    chk("add_acc", 32'(acc), 32'h80);
    chk("add_flags", 32'({of, zf, nf, ovf}), 32'b0011);
    chk("add_done", 32'(done), 32'd1);
    tick();
    chk("add_done_1cyc", 32'(done), 32'd0);

    do_load(8'h0A);
    do_start(4'd1, 8'h0A, 1'b1, 3'd0);
    chk("sub_acc", 32'(acc), 32'hFF);
    chk("sub_flags", 32'({of, zf, nf, ovf}), 32'b1010);

    do_load(8'h0A);
    do_start(4'd2, 8'h0A, 1'b0, 3'd0);
    chk("cmp_acc", 32'(acc), 32'h0A);
    chk("cmp_flags", 32'({of, zf, nf, ovf}), 32'b0100);

    do_load(8'hFF);
    do_start(4'd6, 8'h00, 1'b0, 3'd0);
    chk("inc_acc", 32'(acc), 32'h00);
    chk("inc_flags", 32'({of, zf, nf, ovf}), 32'b1100);

    do_load(8'h80);
    do_start(4'd7, 8'h00, 1'b0, 3'd0);
    chk("dec_acc", 32'(acc), 32'h7F);
    chk("dec_flags", 32'({of, zf, nf, ovf}), 32'b0001);

    do_load(8'hF0);
    do_start(4'd3, 8'h3C, 1'b0, 3'd0);
    chk("and_acc", 32'(acc), 32'h30);
    do_start(4'd4, 8'h0F, 1'b0, 3'd0);
    chk("or_acc", 32'(acc), 32'h3F);
    do_start(4'd5, 8'h00, 1'b0, 3'd0);
    chk("not_acc", 32'(acc), 32'hC0);
    chk("not_flags", 32'({of, zf, nf, ovf}), 32'b0010);

    // rol 0x81 by 3
    do_load(8'h81);
    do_start(4'd14, 8'h00, 1'b0, 3'd3);
    chk("rol_busy0", 32'({busy, done}), 32'b10);
    chk("rol_acc0", 32'(acc), 32'h81);
    tick();
    chk("rol_step1", 32'({busy, acc}), 32'h103);
    tick();
    chk("rol_step2", 32'({busy, acc}), 32'h106);
    tick();
    chk("rol_final", 32'({busy, done, acc}), 32'h10C);
    chk("rol_of", 32'(of), 32'd0);
    tick();
    chk("rol_done_drop", 32'(done), 32'd0);

    // sra 0x90 by 2 with ignored start/load while busy
    do_load(8'h90);
    do_start(4'd13, 8'h00, 1'b0, 3'd2);
    start = 1'b1; load = 1'b1; m = 4'd0; b = 8'h55;
    tick();
    start = 1'b0; load = 1'b0;
    chk("sra_step1", 32'({busy, done, acc}), 32'h2C8);
    tick();
    chk("sra_final", 32'({busy, done, acc}), 32'h1E4);
    chk("sra_flags", 32'({of, nf}), 32'b01);

    // sla 0x40 by 1, then shl by 0
    do_load(8'h40);
    do_start(4'd12, 8'h00, 1'b0, 3'd1);
    chk("sla_busy", 32'(busy), 32'd1);
    tick();
    chk("sla_acc", 32'(acc), 32'h80);
    chk("sla_ovf_done", 32'({ovf, done}), 32'b11);
    do_start(4'd8, 8'h00, 1'b0, 3'd0);
    chk("shl0_acc", 32'(acc), 32'h80);
    chk("shl0_bits", 32'({busy, done, of, ovf}), 32'b0100);

    // ror 0xF0 by 5, reset after second step
    do_load(8'hF0);
    do_start(4'd15, 8'h00, 1'b0, 3'd5);
    tick();
    chk("ror_step1", 32'(acc), 32'h78);
    tick();
    chk("ror_step2", 32'(acc), 32'h3C);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("ror_rst_acc", 32'(acc), 32'h0);
    chk("ror_rst_bits", 32'({busy, done, of, zf, nf, ovf}), 32'h0);
    tick();
    chk("ror_rst_nodone", 32'({busy, done}), 32'h0);
    do_load(8'h01);
    chk("post_rst_flags", 32'({zf, nf}), 32'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
